// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and default widths for the counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int C_DATA_WIDTH = 32;
    localparam int C_DEPTH      = 4;
    localparam int C_WRAP_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [C_DATA_WIDTH-1:0] lower;
        logic [C_DATA_WIDTH-1:0] upper;
        logic [C_WRAP_WIDTH-1:0] wraps;
    } seg_t;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer_if
// Description : Config/control/status bus between register side and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_sequencer_if
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH      = C_DEPTH,
    parameter int WRAP_WIDTH = C_WRAP_WIDTH
) ();
    logic                       cfg_we;
    logic [$clog2(DEPTH)-1:0]   cfg_addr;
    logic [DATA_WIDTH-1:0]      cfg_lower;
    logic [DATA_WIDTH-1:0]      cfg_upper;
    logic [WRAP_WIDTH-1:0]      cfg_wraps;
    logic [$clog2(DEPTH):0]     cfg_num_segs;
    logic                       start;
    logic                       abort;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic [$clog2(DEPTH)-1:0]   seg_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_lower, cfg_upper, cfg_wraps, cfg_num_segs,
        output start, abort,
        input  busy, done, err, seg_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_lower, cfg_upper, cfg_wraps, cfg_num_segs,
        input  start, abort,
        output busy, done, err, seg_idx
    );
endinterface
`default_nettype wire

// File: rtl/seg_table.sv
`default_nettype none
// ============================================================================
// Module      : seg_table
// Description : DEPTH-entry segment register file, one write, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_table #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int WRAP_WIDTH = 8
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_we,
    input  wire logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  wire logic [DATA_WIDTH-1:0]      i_wlower,
    input  wire logic [DATA_WIDTH-1:0]      i_wupper,
    input  wire logic [WRAP_WIDTH-1:0]      i_wwraps,
    input  wire logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic      [DATA_WIDTH-1:0]      o_rlower,
    output logic      [DATA_WIDTH-1:0]      o_rupper,
    output logic      [WRAP_WIDTH-1:0]      o_rwraps
);
    logic [DATA_WIDTH-1:0] r_lower [DEPTH];
    logic [DATA_WIDTH-1:0] r_upper [DEPTH];
    logic [WRAP_WIDTH-1:0] r_wraps [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_lower[i] <= '0;
                r_upper[i] <= '0;
                r_wraps[i] <= '0;
            end
        end else if (i_we) begin
            r_lower[i_waddr] <= i_wlower;
            r_upper[i_waddr] <= i_wupper;
            r_wraps[i_waddr] <= i_wwraps;
        end
    end

    assign o_rlower = r_lower[i_raddr];
    assign o_rupper = r_upper[i_raddr];
    assign o_rwraps = r_wraps[i_raddr];

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : counter_sequencer
// Description : Loads segment bounds into an external wrap-around counter and
//               advances through the segment table as wraps complete.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int DEPTH      = C_DEPTH,
    parameter int WRAP_WIDTH = C_WRAP_WIDTH
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    counter_sequencer_if.slave          bus,
    output logic [DATA_WIDTH-1:0]       cnt_lower_bound,
    output logic [DATA_WIDTH-1:0]       cnt_upper_bound,
    output logic                        cnt_rst,
    input  wire logic [DATA_WIDTH-1:0]  cnt_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] C_MAX_SEGS = NW'(DEPTH);

    seq_state_t             r_state,    w_state_nxt;
    logic [AW-1:0]          r_seg_idx,  w_seg_idx_nxt;
    logic [NW-1:0]          r_num_segs, w_num_segs_nxt;
    logic [WRAP_WIDTH-1:0]  r_wrap_cnt, w_wrap_cnt_nxt;
    logic [WRAP_WIDTH-1:0]  r_target,   w_target_nxt;
    logic [DATA_WIDTH-1:0]  r_lower,    w_lower_nxt;
    logic [DATA_WIDTH-1:0]  r_upper,    w_upper_nxt;
    logic                   r_err,      w_err_nxt;

    logic [AW-1:0]          w_load_idx;
    logic [DATA_WIDTH-1:0]  w_tab_lower;
    logic [DATA_WIDTH-1:0]  w_tab_upper;
    logic [WRAP_WIDTH-1:0]  w_tab_wraps;
    logic                   w_busy;
    logic                   w_last_seg;
    logic                   w_final_wrap;

    assign w_busy = (r_state == S_LOAD) || (r_state == S_RUN);

    // The only table read ever needed is the entry about to be loaded.
    assign w_load_idx = (r_state == S_IDLE) ? '0 : r_seg_idx + AW'(1);

    seg_table #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .WRAP_WIDTH (WRAP_WIDTH)
    ) u_seg_table (
        .clk      (clk),
        .rst      (rst),
        .i_we     (bus.cfg_we && !w_busy),
        .i_waddr  (bus.cfg_addr),
        .i_wlower (bus.cfg_lower),
        .i_wupper (bus.cfg_upper),
        .i_wwraps (bus.cfg_wraps),
        .i_raddr  (w_load_idx),
        .o_rlower (w_tab_lower),
        .o_rupper (w_tab_upper),
        .o_rwraps (w_tab_wraps)
    );

    assign w_last_seg   = ({1'b0, r_seg_idx} + NW'(1)) == r_num_segs;
    assign w_final_wrap = (r_wrap_cnt + WRAP_WIDTH'(1)) == r_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_seg_idx  <= '0;
            r_num_segs <= '0;
            r_wrap_cnt <= '0;
            r_target   <= '0;
            r_lower    <= '0;
            r_upper    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_seg_idx  <= w_seg_idx_nxt;
            r_num_segs <= w_num_segs_nxt;
            r_wrap_cnt <= w_wrap_cnt_nxt;
            r_target   <= w_target_nxt;
            r_lower    <= w_lower_nxt;
            r_upper    <= w_upper_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_seg_idx_nxt  = r_seg_idx;
        w_num_segs_nxt = r_num_segs;
        w_wrap_cnt_nxt = r_wrap_cnt;
        w_target_nxt   = r_target;
        w_lower_nxt    = r_lower;
        w_upper_nxt    = r_upper;
        w_err_nxt      = r_err;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_err_nxt      = 1'b0;
                    w_seg_idx_nxt  = '0;
                    w_wrap_cnt_nxt = '0;
                    if (bus.cfg_num_segs != '0) begin
                        w_state_nxt    = S_LOAD;
                        w_num_segs_nxt = (bus.cfg_num_segs > C_MAX_SEGS) ? C_MAX_SEGS
                                                                         : bus.cfg_num_segs;
                        w_lower_nxt    = w_tab_lower;
                        w_upper_nxt    = w_tab_upper;
                        w_target_nxt   = (w_tab_wraps == '0) ? WRAP_WIDTH'(1) : w_tab_wraps;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_lower > r_upper) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = S_IDLE;
                end else if (cnt_out == r_upper) begin
                    if (!w_final_wrap) begin
                        w_wrap_cnt_nxt = r_wrap_cnt + WRAP_WIDTH'(1);
                    end else if (w_last_seg) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt    = S_LOAD;
                        w_seg_idx_nxt  = w_load_idx;
                        w_wrap_cnt_nxt = '0;
                        w_lower_nxt    = w_tab_lower;
                        w_upper_nxt    = w_tab_upper;
                        w_target_nxt   = (w_tab_wraps == '0) ? WRAP_WIDTH'(1) : w_tab_wraps;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.busy        = w_busy;
    assign bus.done        = (r_state == S_DONE);
    assign bus.err         = r_err;
    assign bus.seg_idx     = r_seg_idx;
    assign cnt_rst         = (r_state != S_RUN);
    assign cnt_lower_bound = r_lower;
    assign cnt_upper_bound = r_upper;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_sequencer
// Description : Self-checking bench: vector table, corner sequences and a
//               randomized run against a cycle-schedule reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;
    import counter_pkg::*;

    localparam int DW    = C_DATA_WIDTH;
    localparam int DEPTH = C_DEPTH;
    localparam int WW    = C_WRAP_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] cnt_lower_bound;
    logic [DW-1:0] cnt_upper_bound;
    logic [DW-1:0] cnt_out;
    logic          cnt_rst;

    int n_checks = 0;
    int n_errors = 0;

    counter_sequencer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WRAP_WIDTH(WW)) bus ();

    counter_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .WRAP_WIDTH(WW)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .cnt_lower_bound (cnt_lower_bound),
        .cnt_upper_bound (cnt_upper_bound),
        .cnt_rst         (cnt_rst),
        .cnt_out         (cnt_out)
    );

    always #5 clk = ~clk;

    // The bounded wrap-around counter the sequencer drives.
    always_ff @(posedge clk) begin
        if (cnt_rst)                         cnt_out <= cnt_lower_bound;
        else if (cnt_out == cnt_upper_bound) cnt_out <= cnt_lower_bound;
        else                                 cnt_out <= cnt_out + 1'b1;
    end

    // Reference model state
    seg_t          m_tab [DEPTH];
    logic [DW-1:0] m_lo = '0;
    logic [DW-1:0] m_up = '0;
    logic          m_err = 1'b0;
    int            m_seg = 0;

    typedef struct {
        logic          busy, done, crst, err, has_cnt;
        int            seg;
        logic [DW-1:0] lo, up, cnt;
    } exp_t;

    typedef struct {
        logic [DW-1:0] lo0, up0, lo1, up1;
        logic [WW-1:0] w0, w1;
        int            n, cyc;
        logic          err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic busy, input logic done, input logic crst,
                                input logic has_cnt, input logic [DW-1:0] cnt);
        exp_t e;
        e.busy = busy; e.done = done; e.crst = crst; e.has_cnt = has_cnt; e.cnt = cnt;
        e.err = m_err; e.seg = m_seg; e.lo = m_lo; e.up = m_up;
        return e;
    endfunction

    function automatic vec_t mkv(input int lo0, input int up0, input int w0, input int lo1,
                                 input int up1, input int w1, input int n, input int cyc,
                                 input int er);
        vec_t v;
        v.lo0 = DW'(lo0); v.up0 = DW'(up0); v.w0 = WW'(w0);
        v.lo1 = DW'(lo1); v.up1 = DW'(up1); v.w1 = WW'(w1);
        v.n = n; v.cyc = cyc; v.err = (er != 0);
        return v;
    endfunction

    task automatic idle_inputs();
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_lower = '0; bus.cfg_upper = '0;
        bus.cfg_wraps = '0; bus.cfg_num_segs = '0; bus.start = 1'b0; bus.abort = 1'b0;
    endtask

    // Called at a safe point (just after a rising edge), only while idle.
    task automatic write_entry(input int idx, input int lo, input int up, input int w);
        bus.cfg_we = 1'b1; bus.cfg_addr = AW'(idx);
        bus.cfg_lower = DW'(lo); bus.cfg_upper = DW'(up); bus.cfg_wraps = WW'(w);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        m_tab[idx].lower = DW'(lo); m_tab[idx].upper = DW'(up); m_tab[idx].wraps = WW'(w);
    endtask

    // Builds the expected per-cycle schedule of a program, then runs and compares it.
    task automatic run_check(input int n, input bit junk);
        exp_t q[$];
        int   nn;
        bit   stop;
        nn = (n > DEPTH) ? DEPTH : n;
        stop = 1'b0;
        m_err = 1'b0;
        m_seg = 0;
        for (int s = 0; s < nn && !stop; s++) begin
            int r, w;
            m_seg = s; m_lo = m_tab[s].lower; m_up = m_tab[s].upper;
            q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, '0));
            if (m_lo > m_up) begin
                m_err = 1'b1;
                stop = 1'b1;
            end else begin
                r = int'(m_up - m_lo) + 1;
                w = (m_tab[s].wraps == '0) ? 1 : int'(m_tab[s].wraps);
                for (int k = 0; k < r * w; k++)
                    q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, m_lo + DW'(k % r)));
            end
        end
        q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, '0));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0));

        bus.cfg_num_segs = NW'(n); bus.start = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        foreach (q[i]) begin
            chk("model_busy",    64'(bus.busy),        64'(q[i].busy));
            chk("model_done",    64'(bus.done),        64'(q[i].done));
            chk("model_cnt_rst", 64'(cnt_rst),         64'(q[i].crst));
            chk("model_err",     64'(bus.err),         64'(q[i].err));
            chk("model_seg_idx", 64'(bus.seg_idx),     64'(q[i].seg));
            chk("model_lower",   64'(cnt_lower_bound), 64'(q[i].lo));
            chk("model_upper",   64'(cnt_upper_bound), 64'(q[i].up));
            if (q[i].has_cnt) chk("model_cnt_out", 64'(cnt_out), 64'(q[i].cnt));
            if (junk && q[i].busy) begin
                bus.cfg_we = 1'($urandom); bus.cfg_addr = AW'($urandom);
                bus.cfg_lower = DW'($urandom); bus.cfg_upper = DW'($urandom);
                bus.cfg_wraps = WW'($urandom); bus.cfg_num_segs = NW'($urandom);
                bus.start = 1'($urandom);
            end else begin
                idle_inputs();
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   cyc;
        vecs[0] = mkv(3, 10, 2, 0, 0, 0, 1, 18, 0);
        vecs[1] = mkv(3, 10, 1, 0, 1, 3, 2, 17, 0);
        vecs[2] = mkv(10, 3, 1, 0, 0, 0, 1, 2, 1);
        vecs[3] = mkv(3, 10, 1, 0, 1, 3, 0, 1, 0);
        vecs[4] = mkv(5, 5, 0, 0, 0, 0, 1, 3, 0);
        vecs[5] = mkv(0, 1, 1, 7, 4, 1, 2, 5, 1);
        vecs[6] = mkv(4, 4, 3, 0, 0, 0, 1, 5, 0);
        vecs[7] = mkv(3, 10, 1, 0, 1, 3, 1, 10, 0);
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",    64'(bus.busy),        0);
        chk("rst_done",    64'(bus.done),        0);
        chk("rst_err",     64'(bus.err),         0);
        chk("rst_seg_idx", 64'(bus.seg_idx),     0);
        chk("rst_cnt_rst", 64'(cnt_rst),         1);
        chk("rst_lower",   64'(cnt_lower_bound), 0);
        chk("rst_upper",   64'(cnt_upper_bound), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(bus.busy), 0);
        run_check(1, 1'b0);

        // Vector table
        foreach (vecs[v]) begin
            write_entry(0, int'(vecs[v].lo0), int'(vecs[v].up0), int'(vecs[v].w0));
            write_entry(1, int'(vecs[v].lo1), int'(vecs[v].up1), int'(vecs[v].w1));
            bus.cfg_num_segs = NW'(vecs[v].n); bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            chk("vec_busy_c1", 64'(bus.busy), 64'(vecs[v].n != 0));
            chk("vec_err_clr", 64'(bus.err), 0);
            cyc = 1;
            while (bus.done !== 1'b1 && cyc < 300) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("vec_done_cycle", 64'(cyc),     64'(vecs[v].cyc));
            chk("vec_err",        64'(bus.err), 64'(vecs[v].err));
            chk("vec_done_crst",  64'(cnt_rst), 1);
            @(posedge clk); #1;
            chk("vec_done_pulse", 64'(bus.done), 0);
            chk("vec_idle_busy",  64'(bus.busy), 0);
        end

        // Abort while the counter shows 6
        write_entry(0, 3, 10, 1);
        bus.cfg_num_segs = NW'(1); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (cnt_out !== DW'(6) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reach6",  64'(cnt_out), 6);
        chk("abort_run_rst", 64'(cnt_rst), 0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_busy",    64'(bus.busy), 0);
        chk("abort_cnt_rst", 64'(cnt_rst),  1);
        chk("abort_done",    64'(bus.done), 0);
        chk("abort_err",     64'(bus.err),  0);
        @(posedge clk); #1;
        chk("abort_no_done", 64'(bus.done), 0);
        run_check(1, 1'b0);

        // Asynchronous reset in the middle of segment 1
        write_entry(0, 0, 1, 1);
        write_entry(1, 3, 10, 2);
        bus.cfg_num_segs = NW'(2); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.seg_idx == AW'(1) && cnt_rst == 1'b0) && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("arst_seg1", 64'(bus.seg_idx), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy",    64'(bus.busy),        0);
        chk("arst_cnt_rst", 64'(cnt_rst),         1);
        chk("arst_seg_idx", 64'(bus.seg_idx),     0);
        chk("arst_done",    64'(bus.done),        0);
        chk("arst_lower",   64'(cnt_lower_bound), 0);
        chk("arst_upper",   64'(cnt_upper_bound), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_tab[i] = '0;
        m_lo = '0; m_up = '0; m_err = 1'b0; m_seg = 0;
        @(posedge clk); #1;
        run_check(1, 1'b0);

        // Randomized programs, with ignored writes/starts thrown in while busy
        for (int p = 0; p < 30; p++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int j = 0; j < nw; j++) begin
                int lo, up;
                lo = int'($urandom_range(0, 12));
                up = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 12))
                                                 : lo + int'($urandom_range(0, 8));
                write_entry(int'($urandom_range(0, DEPTH - 1)), lo, up,
                            int'($urandom_range(0, 3)));
            end
            run_check(int'($urandom_range(0, DEPTH)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_sequencer.md
# counter_sequencer

Controller that programs and sequences the bounded wrap-around counter (bounds `lower_bound`..`upper_bound`, synchronous reset to `lower_bound`, +1 per clock, wraps `upper_bound` -> `lower_bound`). It holds a small table of segments. Each segment is a pair of bounds plus a wrap count. On `start` it loads each segment into the counter, counts completed wraps by watching the counter output, and advances to the next segment. It sits between the register/config side and one counter instance, and owns that counter's bounds and reset.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of bounds and counter output.
- `DEPTH`, 4: number of segment table entries (power of 2).
- `WRAP_WIDTH`, 8: width of per-segment wrap count.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `cfg_we`  in  1: write segment entry `cfg_addr`.
- `cfg_addr`  in  $clog2(DEPTH): table index.
- `cfg_lower`  in  DATA_WIDTH: segment lower bound.
- `cfg_upper`  in  DATA_WIDTH: segment upper bound.
- `cfg_wraps`  in  WRAP_WIDTH: wraps to run; 0 is treated as 1.
- `cfg_num_segs`  in  $clog2(DEPTH)+1: segments to run (0..DEPTH), sampled on accepted `start`.
- `start`  in  1: begin program.
- `abort`  in  1: stop program.
- `busy`  out  1: high in LOAD/RUN.
- `done`  out  1: one-cycle pulse at end of program.
- `err`  out  1: sticky; set by a segment with lower > upper; cleared on accepted `start`.
- `seg_idx`  out  $clog2(DEPTH): active segment.
- `cnt_lower_bound`  out  DATA_WIDTH: to counter `lower_bound`.
- `cnt_upper_bound`  out  DATA_WIDTH: to counter `upper_bound`.
- `cnt_rst`  out  1: to counter `rst`.
- `cnt_out`  in  DATA_WIDTH: from counter `out`.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE: `cnt_rst`=1. `start` && `cfg_num_segs`!=0 -> LOAD, with `seg_idx`=0, wrap counter=0, `err`=0. If `cfg_num_segs`==0, `start` -> DONE.
- LOAD: drive the bounds of entry `seg_idx`; `cnt_rst`=1 for exactly one cycle.
  - lower > upper: set `err` and go to DONE; remaining segments are skipped.
  - Otherwise -> RUN.
- RUN: `cnt_rst`=0. Each cycle with `cnt_out`==`cnt_upper_bound` is one wrap.
  - Wrap count below target: wrap counter +1.
  - Final wrap, last segment: -> DONE.
  - Final wrap, other segment: `seg_idx`+1, wrap counter=0, -> LOAD.
- DONE: `done`=1, `cnt_rst`=1, -> IDLE.
- `abort` in LOAD/RUN -> IDLE next cycle. `done` is not pulsed; `err` is unchanged.
- `start` outside IDLE is ignored.
- `cfg_we` while `busy` is ignored; the table is stable during a run.
- `abort` and `start` in the same IDLE cycle: `start` wins (`abort` has no effect in IDLE).
- A segment with lower == upper wraps every RUN cycle.
- Bound comparisons are unsigned, full DATA_WIDTH.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `seg_idx`=0, `cnt_rst`=1, both bounds 0, table entries 0.
- `start` sampled at edge 0 -> LOAD in cycle 1 -> RUN from cycle 2. The counter shows `cnt_lower_bound` in the first RUN cycle.
- Segment duration: 1 + R·W cycles, where R = upper − lower + 1 and W = max(`cfg_wraps`, 1).
- Program duration: sum of segment durations; `done` follows in the next cycle.
- Bounds change only on entering LOAD and are registered; no combinational path from `cnt_out` to any output.
- `rst` mid-run: all outputs return to reset values immediately (asynchronous), with no `done`.

## Structure
- Package `counter_pkg`: FSM state enum `seq_state_t`, segment struct `seg_t` {lower, upper, wraps}, default width constants.
- Natural sub-module: `seg_table`, a DEPTH-entry register file with one write port and one async read port.
- Top level: FSM, wrap counter, output registers. The counter instance lives outside, in a wrapper or testbench.

## Test plan
- Single segment 3..10, W=2; `start` at edge 0 -> `cnt_rst` low cycles 2..17; `cnt_out` sequence 3..10,3..10; `done` pulse at cycle 18.
- Two segments (3..10 W=1, 0..1 W=3) -> `seg_idx` 0 then 1; LOAD cycle between segments; `done` after 9+7 cycles + 1.
- Entry 0 with lower=10, upper=3 -> `err`=1, `done` pulse, counter never released (`cnt_rst` stays 1).
- `abort` in RUN while `cnt_out`=6 (segment 3..10) -> IDLE next cycle; `cnt_rst`=1; no `done`; the following `start` runs normally.
- Async `rst` pulsed mid-RUN, between clock edges -> `busy`=0, `cnt_rst`=1, `seg_idx`=0 before the next edge.
- `cfg_num_segs`=0 -> `done` one cycle after `start`; `cfg_we` during `busy` leaves the table unchanged, checked by a re-run.
